// File: rtl/bip_core_param.sv
// bip_core_param: parametrised multi-cycle accumulator CPU with branches, Z/N flags,
// run-enable stall and halt, driving external synchronous-read instruction/data memories.
module bip_core_param #(
   parameter int DATA_W    = 16,
   parameter int OPERAND_W = 11,
   parameter int PC_W      = 11,
   parameter int DADDR_W   = 11
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Enable,
   output logic [PC_W-1:0]      imem_addr,
   input  logic [4+OPERAND_W:0] imem_rdata,
   output logic [DADDR_W-1:0]   dmem_addr,
   output logic [DATA_W-1:0]    dmem_wdata,
   output logic                 dmem_we,
   input  logic [DATA_W-1:0]    dmem_rdata,
   output logic [DATA_W-1:0]    acc,
   output logic                 flag_z,
   output logic                 flag_n,
   output logic                 halted
);
   localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, WB = 3'd3, HALT = 3'd4;
   localparam logic [4:0] OP_HLT = 5'b00000, OP_STO = 5'b00001, OP_LD = 5'b00010, OP_LDI = 5'b00011,
                          OP_ADD = 5'b00100, OP_ADDI = 5'b00101, OP_SUB = 5'b00110, OP_SUBI = 5'b00111,
                          OP_BEQ = 5'b01000, OP_BNE = 5'b01001, OP_BRA = 5'b01010;
   logic [2:0]           state;
   logic [PC_W-1:0]      pc, pc_inc, target;
   logic [4+OPERAND_W:0] ir;
   logic [4:0]           opc;
   logic [OPERAND_W-1:0] op;
   logic [DATA_W-1:0]    imm, opnd, acc_nx;
   logic                 mem_rd, is_imm, acc_wr, take;
   always_comb begin
      opc        = ir[4+OPERAND_W:OPERAND_W];
      op         = ir[OPERAND_W-1:0];
      imm        = DATA_W'($signed(op));
      mem_rd     = opc == OP_LD || opc == OP_ADD || opc == OP_SUB;
      is_imm     = opc == OP_LDI || opc == OP_ADDI || opc == OP_SUBI;
      acc_wr     = (state == EXEC && is_imm) || state == WB;
      // WB only follows LD/ADD/SUB, so the same opcode decode serves both operand sources
      opnd       = state == WB ? dmem_rdata : imm;
      acc_nx     = (opc == OP_LD || opc == OP_LDI) ? opnd :
                   (opc == OP_ADD || opc == OP_ADDI) ? acc + opnd : acc - opnd;
      take       = opc == OP_BRA || (opc == OP_BEQ && flag_z) || (opc == OP_BNE && !flag_z);
      pc_inc     = pc + PC_W'(1);
      target     = PC_W'(op);
      imem_addr  = pc;
      dmem_wdata = acc;
      halted     = state == HALT;
      dmem_addr  = (state == EXEC && (mem_rd || opc == OP_STO)) ? DADDR_W'(op) : '0;
      dmem_we    = state == EXEC && opc == OP_STO;
   end
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state  <= FETCH;
         pc     <= '0;
         ir     <= '0;
         acc    <= '0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
      end else begin
         if (acc_wr) begin
            acc    <= acc_nx;
            flag_z <= acc_nx == '0;
            flag_n <= acc_nx[DATA_W-1];
         end
         case (state)
            FETCH:  if (Enable) state <= DECODE;
            DECODE: begin
               ir    <= imem_rdata;
               state <= EXEC;
            end
            EXEC: begin
               state <= opc == OP_HLT ? HALT : mem_rd ? WB : FETCH;
               if (opc != OP_HLT && !mem_rd) pc <= take ? target : pc_inc;
            end
            WB: begin
               pc    <= pc_inc;
               state <= FETCH;
            end
            default: state <= state;
         endcase
      end
   end
endmodule

// File: tb/tb_bip_core_param.sv
// tb_bip_core_param: directed program table plus stall, mid-store reset and
// small-parameter (PC wrap) scenarios for bip_core_param.
module tb_bip_core_param;
   logic Clock = 1'b0, Reset = 1'b1, Enable = 1'b1;
   always #5 Clock = ~Clock;

   localparam logic [4:0] HLT = 5'b00000, STO = 5'b00001, LD = 5'b00010, LDI = 5'b00011,
                          ADD = 5'b00100, ADDI = 5'b00101, SUB = 5'b00110, SUBI = 5'b00111,
                          BEQ = 5'b01000, BNE = 5'b01001, BRA = 5'b01010, NOP = 5'b11111;

   logic [10:0] imem_addr, dmem_addr;
   logic [15:0] imem_rdata, dmem_wdata, dmem_rdata, acc;
   logic        dmem_we, flag_z, flag_n, halted;
   logic [3:0]  imem_addr2;
   logic [15:0] imem_rdata2;
   logic [10:0] dmem_addr2;
   logic [7:0]  dmem_wdata2, dmem_rdata2, acc2;
   logic        dmem_we2, flag_z2, flag_n2, halted2;
   assign dmem_rdata2 = '0;

   bip_core_param dut (
      .Clock(Clock), .Reset(Reset), .Enable(Enable),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
      .acc(acc), .flag_z(flag_z), .flag_n(flag_n), .halted(halted));

   bip_core_param #(.DATA_W(8), .OPERAND_W(11), .PC_W(4), .DADDR_W(11)) dut2 (
      .Clock(Clock), .Reset(Reset), .Enable(Enable),
      .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2), .dmem_we(dmem_we2), .dmem_rdata(dmem_rdata2),
      .acc(acc2), .flag_z(flag_z2), .flag_n(flag_n2), .halted(halted2));

   logic [15:0] imem [2048];
   logic [15:0] dmem [2048];
   logic [15:0] imem2 [16];
   always @(posedge Clock) begin
      imem_rdata  <= imem[imem_addr];
      dmem_rdata  <= dmem[dmem_addr];
      imem_rdata2 <= imem2[imem_addr2];
      if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
   end

   int          we_cnt = 0, wrap_cnt = 0;
   logic [10:0] w_addr;
   logic [15:0] w_data;
   logic [3:0]  prev_pc2;
   always @(negedge Clock) begin
      if (dmem_we) begin
         we_cnt++;
         w_addr = dmem_addr;
         w_data = dmem_wdata;
      end
      if (prev_pc2 == 4'd15 && imem_addr2 == 4'd0) wrap_cnt++;
      prev_pc2 = imem_addr2;
   end

   int total = 0, bad = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] ins(input logic [4:0] o, input logic [10:0] x);
      return {o, x};
   endfunction

   typedef struct {
      logic [127:0] prog;
      logic [15:0]  acc;
      logic         z, n;
      logic [10:0]  pc;
      int           cyc, we;
      logic [10:0]  wa;
      logic [15:0]  wd;
   } vec_t;
   vec_t tv [9];

   task automatic setv(input int k, input logic [127:0] p, input logic [15:0] a, input logic z, input logic n,
                       input logic [10:0] pc, input int cyc, input int we, input logic [10:0] wa, input logic [15:0] wd);
      tv[k].prog = p; tv[k].acc = a; tv[k].z = z; tv[k].n = n; tv[k].pc = pc;
      tv[k].cyc = cyc; tv[k].we = we; tv[k].wa = wa; tv[k].wd = wd;
   endtask

   task automatic start_reset();
      @(negedge Clock);
      Reset = 1'b0;
      for (int i = 0; i < 2048; i++) begin
         imem[i] = '0;
         dmem[i] = '0;
      end
      dmem[5] = 16'h8000;
   endtask

   task automatic end_reset();
      #150;
      Reset = 1'b1;
   endtask

   task automatic wait_halt(input int budget, output int cyc);
      cyc = 0;
      while (!halted && cyc < budget) begin
         @(posedge Clock);
         #1;
         cyc++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal;
   end

   initial begin
      int cyc, wb;
      for (int i = 0; i < 16; i++) imem2[i] = '0;
      imem2[0]  = ins(BNE, 11'd28);
      imem2[12] = ins(LDI, 11'd3);
      imem2[13] = ins(SUBI, 11'd1);
      imem2[14] = ins(BNE, 11'd13);
      imem2[15] = ins(NOP, 11'd0);

      setv(0, {ins(LDI, 5), ins(HLT, 0), 96'h0}, 16'd5, 0, 0, 1, 6, 0, 0, 0);
      setv(1, {ins(LDI, 7), ins(STO, 3), ins(LDI, 0), ins(ADD, 3), ins(SUB, 3), ins(HLT, 0), 32'h0},
           16'd0, 1, 0, 5, 20, 1, 3, 16'd7);
      setv(2, {ins(LDI, 3), ins(SUBI, 1), ins(BNE, 1), ins(HLT, 0), 64'h0}, 16'd0, 1, 0, 3, 24, 0, 0, 0);
      setv(3, {ins(LDI, 11'h7FF), ins(HLT, 0), 96'h0}, 16'hFFFF, 0, 1, 1, 6, 0, 0, 0);
      setv(4, {ins(LDI, 11'h7FF), ins(ADDI, 1), ins(HLT, 0), 80'h0}, 16'h0000, 1, 0, 2, 9, 0, 0, 0);
      setv(5, {ins(LDI, 2), ins(SUBI, 5), ins(ADDI, 11'h400), ins(HLT, 0), 64'h0}, 16'hFBFD, 0, 1, 3, 12, 0, 0, 0);
      setv(6, {ins(LDI, 0), ins(BEQ, 4), ins(LDI, 9), ins(HLT, 0), ins(LDI, 1), ins(BEQ, 2), ins(HLT, 0), 16'h0},
           16'd1, 0, 0, 6, 15, 0, 0, 0);
      setv(7, {ins(LD, 5), ins(NOP, 0), ins(BRA, 4), ins(HLT, 0), ins(ADD, 5), ins(HLT, 0), 32'h0},
           16'd0, 1, 0, 5, 17, 0, 0, 0);
      setv(8, {ins(LDI, 0), ins(STO, 2), ins(HLT, 0), 80'h0}, 16'd0, 1, 0, 2, 9, 1, 2, 16'd0);

      // reset values while held in reset
      start_reset();
      #20;
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_acc", acc, 0);
      chk("rst_halted", halted, 0);
      chk("rst_we", dmem_we, 0);
      chk("rst_dmem_addr", dmem_addr, 0);
      chk("rst_flags", {flag_z, flag_n}, 0);
      end_reset();

      for (int k = 0; k < 9; k++) begin
         start_reset();
         for (int i = 0; i < 8; i++) imem[i] = tv[k].prog[127-16*i -: 16];
         end_reset();
         wb = we_cnt;
         wait_halt(300, cyc);
         chk($sformatf("v%0d_cycles", k), cyc, tv[k].cyc);
         chk($sformatf("v%0d_acc", k), acc, tv[k].acc);
         chk($sformatf("v%0d_z", k), flag_z, tv[k].z);
         chk($sformatf("v%0d_n", k), flag_n, tv[k].n);
         repeat (3) @(posedge Clock);
         #1;
         chk($sformatf("v%0d_pc", k), imem_addr, tv[k].pc);
         chk($sformatf("v%0d_acc_frozen", k), acc, tv[k].acc);
         chk($sformatf("v%0d_we_cnt", k), we_cnt - wb, tv[k].we);
         if (tv[k].we > 0) begin
            chk($sformatf("v%0d_waddr", k), w_addr, tv[k].wa);
            chk($sformatf("v%0d_wdata", k), w_data, tv[k].wd);
         end
      end

      // Enable dropped while ADD is in DECODE: ADD finishes, then the core stalls in FETCH
      start_reset();
      imem[0] = ins(LDI, 1);
      imem[1] = ins(ADD, 3);
      imem[2] = ins(ADDI, 1);
      dmem[3] = 16'd5;
      end_reset();
      repeat (4) @(posedge Clock);
      #1;
      Enable = 1'b0;
      chk("stall_pc_in_add", imem_addr, 1);
      repeat (12) @(posedge Clock);
      #1;
      chk("stall_acc", acc, 6);
      chk("stall_pc", imem_addr, 2);
      chk("stall_halted", halted, 0);
      Enable = 1'b1;
      wait_halt(100, cyc);
      chk("resume_cycles", cyc, 6);
      chk("resume_acc", acc, 7);
      chk("resume_pc", imem_addr, 3);

      // Reset dropped while STO is in EXEC
      start_reset();
      imem[0] = ins(LDI, 9);
      imem[1] = ins(STO, 4);
      end_reset();
      repeat (5) @(posedge Clock);
      #1;
      chk("sto_we", dmem_we, 1);
      chk("sto_addr", dmem_addr, 4);
      chk("sto_wdata", dmem_wdata, 9);
      #1;
      Reset = 1'b0;
      #1;
      chk("abort_we", dmem_we, 0);
      chk("abort_addr", dmem_addr, 0);
      chk("abort_pc", imem_addr, 0);
      chk("abort_acc", acc, 0);
      repeat (2) @(posedge Clock);
      #1;
      chk("abort_mem", dmem[4], 0);

      // 8-bit / 4-bit-PC instance: loop that falls through 15 -> 0
      start_reset();
      end_reset();
      wb = wrap_cnt;
      cyc = 0;
      while (!halted2 && cyc < 200) begin
         @(posedge Clock);
         #1;
         cyc++;
      end
      chk("p2_cycles", cyc, 33);
      chk("p2_acc", acc2, 0);
      chk("p2_z", flag_z2, 1);
      chk("p2_n", flag_n2, 0);
      chk("p2_pc", imem_addr2, 1);
      chk("p2_wrap", wrap_cnt - wb, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
